// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  localparam int unsigned DIV_WIDTH = 64;

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle between the execute stage and the divider.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output in_valid, dividend, divisor, is_signed, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, is_signed, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/full_adder.sv
// 1-bit full adder cell.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// File: rtl/trial_sub.sv
// Ripple subtractor a - b built as a + ~b + 1; o_borrow set when a < b.
module trial_sub #(
  parameter int unsigned WIDTH = 65
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);
  logic [WIDTH:0] w_carry;

  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    full_adder u_fa (
      .i_a    (i_a[g]),
      .i_b    (~i_b[g]),
      .i_cin  (w_carry[g]),
      .o_sum  (o_diff[g]),
      .o_cout (w_carry[g+1])
    );
  end

  assign o_borrow = ~w_carry[WIDTH];
endmodule

// File: rtl/seq_divider.sv
// Restoring divider, one trial subtraction per clock, signed/unsigned with
// sign fix-up applied on the final iteration.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);
  localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  div_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic             w_unused;

  // r_dvd doubles as the quotient shift register: dividend bits leave at the
  // MSB while quotient bits enter at the LSB.
  assign w_shift = {r_rem, r_dvd[WIDTH-1]};

  trial_sub #(.WIDTH(WIDTH + 1)) u_sub (
    .i_a      (w_shift),
    .i_b      ({1'b0, r_dvs}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  // Kept remainder is always below the divisor, so the top diff bit is zero.
  assign w_unused   = w_diff[WIDTH];
  assign w_rem_next = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_next = {r_dvd[WIDTH-2:0], ~w_borrow};

  assign w_dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
  assign w_dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];
  assign w_dvd_abs = w_dvd_neg ? -bus.dividend : bus.dividend;
  assign w_dvs_abs = w_dvs_neg ? -bus.divisor  : bus.divisor;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_rem  <= '0;
            r_cnt  <= '0;
            r_dvd  <= w_dvd_abs;
            r_dvs  <= w_dvs_abs;
            r_qneg <= w_dvd_neg ^ w_dvs_neg;
            r_rneg <= w_dvd_neg;
            if (bus.divisor == '0) begin
              r_quot  <= '1;
              r_remo  <= bus.dividend;
              r_dz    <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_dvd <= w_quo_next;
          if (r_cnt == LAST) begin
            r_quot  <= r_qneg ? -w_quo_next : w_quo_next;
            r_remo  <= r_rneg ? -w_rem_next : w_rem_next;
            r_dz    <= 1'b0;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_remo;
  assign bus.div_zero  = r_dz;
endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider with hand-computed results.
module tb_seq_divider;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_mis;
  int   lat;

  seq_divider_if #(.WIDTH(64)) bus ();

  seq_divider #(.WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer operands, wait for accept, then count edges until out_valid.
  task automatic run_div(input logic [63:0] a, input logic [63:0] b, input logic s,
                         output int edges);
    int guard;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = s;
    bus.in_valid  = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      tick();
      guard++;
    end
    check_eq("accept_wait", 64'(guard < 200), 64'd1);
    tick();
    bus.in_valid  = 1'b0;
    bus.dividend  = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.divisor   = 64'h0BAD_0BAD_0BAD_0BAD;
    bus.is_signed = ~s;
    edges = 0;
    while (!bus.out_valid && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq("consume_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("consume_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic check_result(input string tag, input int edges, input int exp_edges,
                              input logic [63:0] q, input logic [63:0] r, input logic dz);
    check_eq({tag, "_latency"}, 64'(edges), 64'(exp_edges));
    check_eq({tag, "_quot"}, bus.quotient, q);
    check_eq({tag, "_rem"}, bus.remainder, r);
    check_eq({tag, "_dz"}, 64'(bus.div_zero), 64'(dz));
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    reset = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.is_signed = 1'b0;
    #2;
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_dz", 64'(bus.div_zero), 64'd0);
    check_eq("rst_quot", bus.quotient, 64'd0);
    check_eq("rst_rem", bus.remainder, 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    run_div(64'd100, 64'd7, 1'b0, lat);
    check_result("u100_7", lat, 64, 64'd14, 64'd2, 1'b0);
    consume();

    run_div(64'd7, 64'd100, 1'b0, lat);
    check_result("u7_100", lat, 64, 64'd0, 64'd7, 1'b0);
    consume();

    run_div(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, lat);
    check_result("sm100_7", lat, 64, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    consume();

    run_div(64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, lat);
    check_result("s100_m7", lat, 64, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0);
    consume();

    run_div(64'h1234, 64'd0, 1'b0, lat);
    check_result("u_divzero", lat, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1);
    consume();

    run_div(64'h1234, 64'd0, 1'b1, lat);
    check_result("s_divzero", lat, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1);
    consume();

    run_div(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, lat);
    check_result("s_overflow", lat, 64, 64'h8000_0000_0000_0000, 64'd0, 1'b0);
    consume();

    run_div(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat);
    check_result("u_max_1", lat, 64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
    consume();

    // Back-pressure: result must hold while out_ready stays low.
    run_div(64'd1000, 64'd10, 1'b0, lat);
    check_result("u1000_10", lat, 64, 64'd100, 64'd0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      check_eq("hold_quot", bus.quotient, 64'd100);
      check_eq("hold_rem", bus.remainder, 64'd0);
      check_eq("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check_eq("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    consume();
    run_div(64'd77, 64'd8, 1'b0, lat);
    check_result("b2b_77_8", lat, 64, 64'd9, 64'd5, 1'b0);
    consume();

    // Abort mid-divide with an asynchronous reset.
    bus.dividend  = 64'd12345;
    bus.divisor   = 64'd17;
    bus.is_signed = 1'b0;
    bus.in_valid  = 1'b1;
    check_eq("abort_pre_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    repeat (30) tick();
    check_eq("abort_busy", 64'(bus.out_valid), 64'd0);
    reset = 1'b0;
    #1;
    check_eq("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("abort_quot", bus.quotient, 64'd0);
    check_eq("abort_rem", bus.remainder, 64'd0);
    check_eq("abort_dz", 64'(bus.div_zero), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    check_eq("post_abort_idle", 64'(bus.out_valid), 64'd0);
    run_div(64'd9, 64'd3, 1'b0, lat);
    check_result("u9_3", lat, 64, 64'd3, 64'd0, 1'b0);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
